// File: rtl/alct_rx_phase_scan.sv
// ALCT 80 MHz receive-path calibration: sweeps {posneg, delay tap}, checks the loopback pattern
// at each point, then applies the centre of the longest passing window.
module alct_rx_phase_scan #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] PAT1ST  = 16'hAAAA,
    parameter logic [WIDTH-1:0] PAT2ND  = 16'h5555,
    parameter int unsigned      SETTLE  = 8,
    parameter int unsigned      NSAMPLE = 64
) (
    input  logic             clock_i,
    input  logic             clr_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dout1st_i,
    input  logic [WIDTH-1:0] dout2nd_i,
    input  logic             dly_busy_i,
    output logic             posneg_o,
    output logic [3:0]       dly_tap_o,
    output logic             dly_load_o,
    output logic             demux_clr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             fail_o,
    output logic [31:0]      pass_map_o,
    output logic [4:0]       best_idx_o,
    output logic [5:0]       best_len_o
);

    localparam logic [9:0] SettleLast = 10'(SETTLE - 1);
    localparam logic [9:0] CheckLast  = 10'(NSAMPLE - 1);

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StWaitB,
        StSettle,
        StCheck,
        StNext,
        StEval,
        StApply,
        StApWait,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [4:0]  set_q, set_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        mis_q, mis_d;
    logic [31:0] pass_map_q, pass_map_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic [4:0]  best_idx_q, best_idx_d;
    logic [5:0]  best_len_q, best_len_d;
    logic [5:0]  run_len_q, run_len_d;
    logic [4:0]  run_start_q, run_start_d;
    logic [5:0]  bl_q, bl_d;
    logic [4:0]  bs_q, bs_d;

    logic        pat_err;
    logic        ev_bit;
    logic [5:0]  ev_len;
    logic [4:0]  ev_start;
    logic [5:0]  ev_bl;
    logic [4:0]  ev_bs;
    logic [4:0]  ev_center;
    logic        start_ok;

    assign pat_err  = (dout1st_i != PAT1ST) || (dout2nd_i != PAT2ND);
    assign start_ok = start_i && ((state_q == StIdle) || (state_q == StDone));

    // One pass_map bit per EVAL cycle; strict '>' keeps the earliest of equal-length runs.
    always_comb begin
        ev_bit    = pass_map_q[cnt_q[4:0]];
        ev_len    = ev_bit ? (run_len_q + 6'd1) : 6'd0;
        ev_start  = (run_len_q == 6'd0) ? cnt_q[4:0] : run_start_q;
        ev_bl     = bl_q;
        ev_bs     = bs_q;
        if (ev_bit && (ev_len > bl_q)) begin
            ev_bl = ev_len;
            ev_bs = ev_start;
        end
        ev_center = (ev_bl == 6'd0) ? 5'd0 : (ev_bs + 5'((ev_bl - 6'd1) >> 1));
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        set_d       = set_q;
        cnt_d       = cnt_q;
        mis_d       = mis_q;
        pass_map_d  = pass_map_q;
        done_d      = done_q;
        fail_d      = fail_q;
        best_idx_d  = best_idx_q;
        best_len_d  = best_len_q;
        run_len_d   = run_len_q;
        run_start_d = run_start_q;
        bl_d        = bl_q;
        bs_d        = bs_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    pass_map_d = '0;
                    done_d     = 1'b0;
                    fail_d     = 1'b0;
                    idx_d      = '0;
                    set_d      = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: state_d = StWaitB;
            StWaitB: begin
                if (!dly_busy_i) begin
                    cnt_d   = '0;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = '0;
                    mis_d   = 1'b0;
                    state_d = StCheck;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StCheck: begin
                mis_d = mis_q | pat_err;
                if (cnt_q == CheckLast) begin
                    state_d = StNext;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StNext: begin
                pass_map_d[idx_q] = ~mis_q;
                if (idx_q == 5'd31) begin
                    cnt_d       = '0;
                    run_len_d   = '0;
                    run_start_d = '0;
                    bl_d        = '0;
                    bs_d        = '0;
                    state_d     = StEval;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    set_d   = idx_q + 5'd1;
                    state_d = StLoad;
                end
            end
            StEval: begin
                run_len_d   = ev_len;
                run_start_d = ev_start;
                bl_d        = ev_bl;
                bs_d        = ev_bs;
                if (cnt_q[4:0] == 5'd31) begin
                    best_len_d = ev_bl;
                    best_idx_d = ev_center;
                    fail_d     = (ev_bl == 6'd0);
                    set_d      = ev_center;
                    state_d    = StApply;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            StApply: state_d = StApWait;
            StApWait: begin
                if (!dly_busy_i) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (clr_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            set_q       <= '0;
            cnt_q       <= '0;
            mis_q       <= 1'b0;
            pass_map_q  <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            best_idx_q  <= '0;
            best_len_q  <= '0;
            run_len_q   <= '0;
            run_start_q <= '0;
            bl_q        <= '0;
            bs_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            set_q       <= set_d;
            cnt_q       <= cnt_d;
            mis_q       <= mis_d;
            pass_map_q  <= pass_map_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            best_idx_q  <= best_idx_d;
            best_len_q  <= best_len_d;
            run_len_q   <= run_len_d;
            run_start_q <= run_start_d;
            bl_q        <= bl_d;
            bs_q        <= bs_d;
        end
    end

    assign posneg_o    = set_q[4];
    assign dly_tap_o   = set_q[3:0];
    assign dly_load_o  = (state_q == StLoad) || (state_q == StApply);
    assign demux_clr_o = ((state_q == StWaitB) || (state_q == StApWait)) && !dly_busy_i;
    assign busy_o      = (state_q != StIdle) && (state_q != StDone);
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign pass_map_o  = pass_map_q;
    assign best_idx_o  = best_idx_q;
    assign best_len_o  = best_len_q;

endmodule
